// File: rtl/pc_fetch_unit.sv
// Program counter for the single-cycle MIPS core: next-PC selection, self-jump HALT and retired count.
// Optional PC range fault is built only when PC_RANGE_CHECK_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pc_src,
  input  logic             branch_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jump_target,
  input  logic [31:0]      jr_target,
  input  logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus_4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  logic [31:0]      next_pc_c;
  logic [31:0]      branch_off_c;
  logic             self_jump_c;
  logic             range_err_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             unused_jr_low;

  assign pc_plus_4     = pc_q + 32'd4;
  assign branch_off_c  = {{14{imm16[15]}}, imm16, 2'b00};
  assign self_jump_c   = (instruction == {6'h02, pc_q[27:2]});
  assign cnt_inc_c     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign unused_jr_low = ^jr_target[1:0];

  // Next-PC mux; all arithmetic wraps silently at 2^32.
  always_comb begin
    next_pc_c = pc_plus_4;
    case (pc_src)
      SRC_SEQ:    next_pc_c = pc_plus_4;
      SRC_BRANCH: next_pc_c = branch_taken ? (pc_plus_4 + branch_off_c) : pc_plus_4;
      SRC_JUMP:   next_pc_c = {pc_plus_4[31:28], jump_target, 2'b00};
      default:    next_pc_c = {jr_target[31:2], 2'b00};
    endcase
  end

`ifdef PC_RANGE_CHECK_EN
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  assign range_err_c = ({1'b0, next_pc_c} >= IMEM_BYTES);
`else
  logic unused_imem_words;

  assign range_err_c       = 1'b0;
  assign unused_imem_words = |IMEM_WORDS;
`endif

  // Stall takes precedence over halt detection; the self-jump retires before freezing.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    if (state_q == S_RUN && !stall) begin
      if (self_jump_c) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
        cnt_d    = cnt_inc_c;
      end else if (range_err_c) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end else begin
        pc_d  = next_pc_c;
        cnt_d = cnt_inc_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign pc            = pc_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed vectors push expectations, a monitor pops and compares.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        halted;
    logic        fault;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] instruction = '0;

  logic [31:0] pc, pc_plus_4, s_pc, s_pc_plus_4;
  logic        halted, fault, s_halted, s_fault;
  logic [31:0] retired_count;
  logic [1:0]  s_count;

  always #5 clk = ~clk;

  pc_fetch_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_taken(branch_taken), .imm16(imm16), .jump_target(jump_target),
    .jr_target(jr_target), .instruction(instruction), .pc(pc),
    .pc_plus_4(pc_plus_4), .halted(halted), .fault(fault),
    .retired_count(retired_count)
  );

  // Narrow counter copy so the saturation limit is reachable.
  pc_fetch_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_taken(branch_taken), .imm16(imm16), .jump_target(jump_target),
    .jr_target(jr_target), .instruction(instruction), .pc(s_pc),
    .pc_plus_4(s_pc_plus_4), .halted(s_halted), .fault(s_fault),
    .retired_count(s_count)
  );

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, req);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] sat;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        sat = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
        cmp(e.name, "pc", pc, e.pc);
        cmp(e.name, "pc_plus_4", pc_plus_4, e.pc + 32'd4);
        cmp(e.name, "count", retired_count, e.cnt);
        cmp(e.name, "halted", 32'(halted), 32'(e.halted));
        cmp(e.name, "fault", 32'(fault), 32'(e.fault));
        cmp(e.name, "sat_count", 32'(s_count), sat);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] epc, input logic [31:0] ecnt,
                          input logic eh, input logic ef);
    exp_t e;
    e.pc = epc; e.cnt = ecnt; e.halted = eh; e.fault = ef; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input string nm, input logic st, input logic [1:0] src, input logic tk,
                      input logic [15:0] imm, input logic [25:0] jt, input logic [31:0] jr,
                      input logic [31:0] ins, input logic [31:0] epc, input logic [31:0] ecnt,
                      input logic eh, input logic ef);
    @(negedge clk);
    stall = st; pc_src = src; branch_taken = tk; imm16 = imm;
    jump_target = jt; jr_target = jr; instruction = ins;
    push_exp(nm, epc, ecnt, eh, ef);
  endtask

  // Reset asserted between edges must take effect before the next clock.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    stall = 1'b1;
    instruction = '0;
    reset = 1'b1;
    push_exp(nm, 32'h0, 32'd0, 1'b0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #3;
    push_exp("reset_init", 32'h0, 32'd0, 1'b0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    reset = 1'b0;

    //    name          st   src    tk    imm       jt     jr            instr          pc     cnt  h     f
    step("seq1",        0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h04, 1,  0, 0);
    step("seq2",        0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h08, 2,  0, 0);
    step("seq3",        0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h0C, 3,  0, 0);
    step("stall1",      1, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h0C, 3,  0, 0);
    step("stall2",      1, 2'b01, 1, 16'h0040, 26'd0, 32'h0,        32'h0,         32'h0C, 3,  0, 0);
    step("seq4",        0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h10, 4,  0, 0);
    step("br_taken",    0, 2'b01, 1, 16'h0001, 26'd0, 32'h0,        32'h0,         32'h18, 5,  0, 0);
    step("jr_back",     0, 2'b11, 0, 16'h0000, 26'd0, 32'h10,       32'h0,         32'h10, 6,  0, 0);
    step("br_not",      0, 2'b01, 0, 16'h0001, 26'd0, 32'h0,        32'h0,         32'h14, 7,  0, 0);
    step("jr_back2",    0, 2'b11, 0, 16'h0000, 26'd0, 32'h10,       32'h0,         32'h10, 8,  0, 0);
    step("br_neg",      0, 2'b01, 1, 16'hFFFF, 26'd0, 32'h0,        32'h0,         32'h10, 9,  0, 0);
    step("jump",        0, 2'b10, 0, 16'h0000, 26'd6, 32'h0,        32'h0,         32'h18, 10, 0, 0);
    step("jr_align",    0, 2'b11, 0, 16'h0000, 26'd0, 32'h23,       32'h0,         32'h20, 11, 0, 0);
    step("stall_selfj", 1, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0800_0008, 32'h20, 11, 0, 0);
    step("jr_2c",       0, 2'b11, 0, 16'h0000, 26'd0, 32'h2C,       32'h0,         32'h2C, 12, 0, 0);
    step("halt",        0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0800_000B, 32'h2C, 13, 1, 0);
    step("halt_frz1",   0, 2'b11, 0, 16'h0000, 26'd0, 32'h100,      32'h0,         32'h2C, 13, 1, 0);
    step("halt_frz2",   0, 2'b01, 1, 16'h0010, 26'd0, 32'h0,        32'h0800_000B, 32'h2C, 13, 1, 0);
    do_reset("reset_halt");

    step("jr_3fc",      0, 2'b11, 0, 16'h0000, 26'd0, 32'h3FC,      32'h0,         32'h3FC, 1, 0, 0);
`ifdef PC_RANGE_CHECK_EN
    step("seq_edge",    0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h3FC, 1, 1, 1);
    step("fault_frz",   0, 2'b11, 0, 16'h0000, 26'd0, 32'h10,       32'h0,         32'h3FC, 1, 1, 1);
`else
    step("seq_edge",    0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h400, 2, 0, 0);
    step("seq_past",    0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h404, 3, 0, 0);
`endif
    do_reset("reset_range");
`ifdef PC_RANGE_CHECK_EN
    step("jr_400",      0, 2'b11, 0, 16'h0000, 26'd0, 32'h400,      32'h0,         32'h0,   0, 1, 1);
`else
    step("jr_400",      0, 2'b11, 0, 16'h0000, 26'd0, 32'h400,      32'h0,         32'h400, 1, 0, 0);
    step("seq_sat",     0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h404, 2, 0, 0);
    step("seq_sat2",    0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h408, 3, 0, 0);
    step("seq_sat3",    0, 2'b00, 0, 16'h0000, 26'd0, 32'h0,        32'h0,         32'h40C, 4, 0, 0);
`endif

    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
